// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider for the EX stage (DIV/DIVU), result {remainder, quotient}.
// Optional `DIV_EARLY_EXIT_EN: skip the iterations when |dividend| < |divisor|.
`timescale 1ns/1ps

module ex_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {StIdle, StZero, StOn, StEnd} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;      // dividend magnitude, quotient bits shift in at the LSB
   logic [31:0] rem_q, rem_d;      // partial remainder
   logic [31:0] dsr_q, dsr_d;      // divisor magnitude
   logic        neg_quot_q, neg_quot_d;
   logic        neg_rem_q, neg_rem_d;
   logic        early_q, early_d;
   logic        ready_q, ready_d;
   logic [63:0] result_q, result_d;

   logic [31:0] abs1, abs2;
   logic [32:0] shifted, diff;
   logic [31:0] quot_nx, rem_nx, quot_fix, rem_fix;

   always_comb begin
      abs1     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      abs2     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
      shifted  = {rem_q, dvd_q[31]};
      diff     = shifted - {1'b0, dsr_q};
      quot_nx  = {dvd_q[30:0], ~diff[32]};
      rem_nx   = diff[32] ? shifted[31:0] : diff[31:0];
      quot_fix = neg_quot_q ? (~quot_nx + 32'd1) : quot_nx;
      rem_fix  = neg_rem_q ? (~rem_nx + 32'd1) : rem_nx;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      rem_d      = rem_q;
      dsr_d      = dsr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      early_d    = early_q;
      ready_d    = ready_q;
      result_d   = result_q;

      unique case (state_q)
         StIdle: begin
            if (start_i && !annul_i) begin
               neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
               neg_rem_d  = signed_div_i && opdata1_i[31];
               early_d    = 1'b0;
               if (opdata2_i == 32'd0) begin
                  state_d = StZero;
`ifdef DIV_EARLY_EXIT_EN
               end else if (abs1 < abs2) begin
                  // Quotient is zero; remainder is the dividend exactly as given.
                  state_d = StZero;
                  early_d = 1'b1;
                  rem_d   = opdata1_i;
`endif
               end else begin
                  state_d = StOn;
                  dvd_d   = abs1;
                  dsr_d   = abs2;
                  rem_d   = 32'd0;
                  cnt_d   = 5'd0;
               end
            end
         end
         StZero: begin
            state_d  = StEnd;
            ready_d  = 1'b1;
            result_d = early_q ? {rem_q, 32'd0} : 64'd0;
         end
         StOn: begin
            dvd_d = quot_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = StEnd;
               ready_d  = 1'b1;
               result_d = {rem_fix, quot_fix};
               cnt_d    = 5'd0;
            end
         end
         StEnd: begin
            if (!start_i) begin
               state_d  = StIdle;
               ready_d  = 1'b0;
               result_d = 64'd0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (annul_i && (state_q != StIdle)) begin
         state_d  = StIdle;
         cnt_d    = 5'd0;
         ready_d  = 1'b0;
         result_d = 64'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         dvd_q      <= 32'd0;
         rem_q      <= 32'd0;
         dsr_q      <= 32'd0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         early_q    <= 1'b0;
         ready_q    <= 1'b0;
         result_q   <= 64'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_q      <= dvd_d;
         rem_q      <= rem_d;
         dsr_q      <= dsr_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         early_q    <= early_d;
         ready_q    <= ready_d;
         result_q   <= result_d;
      end
   end

   assign ready_o    = ready_q;
   assign result_o   = result_q;
   assign stallreq_o = ~rst & start_i & ~annul_i & ~ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: arithmetic reference model plus a per-cycle compare process.
`timescale 1ns/1ps

module tb_ex_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   ex_div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   logic        chk_en      = 1'b0;
   logic        exp_ready   = 1'b0;
   logic        exp_res_chk = 1'b0;
   logic [63:0] exp_result  = 64'd0;

   // Reference: plain 64-bit arithmetic; truncating division gives the MIPS sign rules.
   function automatic logic [63:0] model_result(logic sgn, logic [31:0] a, logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int model_latency(logic sgn, logic [31:0] a, logic [31:0] b);
      longint ma, mb;
      if (b == 32'd0) return 3;
      ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_EXIT_EN
      if (ma < mb) return 3;
`endif
      return 34;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
         check("stallreq_o", {63'd0, stallreq_o},
               {63'd0, ~rst & start_i & ~annul_i & ~exp_ready});
         if (exp_res_chk) check("result_o", result_o, exp_ready ? exp_result : 64'd0);
      end
   end

   // Drives cycles 1..n of a divide with start held; returns at the start of cycle n+1.
   task automatic run_partial(logic sgn, logic [31:0] a, logic [31:0] b, int n);
      int lat;
      lat          = model_latency(sgn, a, b);
      exp_result   = model_result(sgn, a, b);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      for (int k = 1; k <= n; k++) begin
         exp_ready   = (k >= lat);
         exp_res_chk = (k == 1) || (k >= lat);
         if (k == 2) begin
            // Operands are latched; later changes must not matter.
            opdata1_i = ~a;
            opdata2_i = b ^ 32'h5;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_div(logic sgn, logic [31:0] a, logic [31:0] b, logic [63:0] lit,
                          string tag);
      int lat;
      check({tag, " model"}, model_result(sgn, a, b), lit);
      lat = model_latency(sgn, a, b);
      run_partial(sgn, a, b, lat + 1);
      start_i     = 1'b0;
      exp_ready   = 1'b1;
      exp_res_chk = 1'b1;
      @(posedge clk);
      #1;
      exp_ready   = 1'b0;
      exp_res_chk = 1'b1;
   endtask

   initial begin
      rst          = 1'b1;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      exp_ready    = 1'b0;
      exp_res_chk  = 1'b1;
      chk_en       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start_i = 1'b0;
      rst     = 1'b0;
      @(posedge clk);
      #1;

      run_div(1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, "divu 100/7");
      run_div(1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, "div -7/2");
      run_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, "div ovf");
      run_div(1'b0, 32'd5,          32'd0,          64'h00000000_00000000, "divu 5/0");
      run_div(1'b0, 32'd3,          32'd10,         64'h00000003_00000000, "divu 3/10");
      run_div(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, "div 7/-2");
      run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, "div -100/-7");
      run_div(1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, "divu max/1");
      run_div(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, "divu max/max");
      run_div(1'b1, 32'h80000000,   32'd2,          64'h00000000_C0000000, "div min/2");
      run_div(1'b1, 32'hFFFFFFFD,   32'd10,         64'hFFFFFFFD_00000000, "div -3/10");
      run_div(1'b0, 32'h80000000,   32'h80000001,   64'h80000000_00000000, "divu near");
      run_div(1'b1, 32'hFFFFFFFB,   32'd0,          64'h00000000_00000000, "div -5/0");

      // Annul in cycle 10: back to IDLE, no ready, then a clean restart.
      run_partial(1'b0, 32'd9, 32'd3, 9);
      annul_i     = 1'b1;
      exp_ready   = 1'b0;
      exp_res_chk = 1'b0;
      @(posedge clk);
      #1;
      annul_i     = 1'b0;
      start_i     = 1'b0;
      exp_res_chk = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "divu 9/3 restart");

      // Reset asserted mid-divide in cycle 20.
      run_partial(1'b0, 32'd100, 32'd7, 19);
      rst         = 1'b1;
      exp_ready   = 1'b0;
      exp_res_chk = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      #1;

      // Reset while the result is being held in END clears outputs without a clock edge.
      run_partial(1'b0, 32'd100, 32'd7, 35);
      rst         = 1'b1;
      exp_ready   = 1'b0;
      exp_res_chk = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      #1;

      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div -7/2 after rst");

      // Annul while holding the result in END.
      run_partial(1'b0, 32'd5, 32'd0, 4);
      annul_i     = 1'b1;
      exp_ready   = 1'b1;
      exp_res_chk = 1'b1;
      @(posedge clk);
      #1;
      annul_i     = 1'b0;
      start_i     = 1'b0;
      exp_ready   = 1'b0;
      exp_res_chk = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider for the EX stage of the five-stage MIPS pipeline. It consumes the operand pair that the ID/EX pipeline register delivers (ex_reg1 = dividend, ex_reg2 = divisor) for DIV/DIVU. It raises the EX stall request back toward the pipeline controller until the result is ready. Quotient and remainder are returned as one 64-bit word for the HI/LO write path.

## Interface
Parameters: none (widths fixed at 32-bit operands, 64-bit result).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset (`RstEnable` = 1)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  EX requests a divide; held high by EX until ready_o is seen
- annul_i  in  1  abort current divide (pipeline flush); overrides start_i
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1
- ready_o  out  1  result valid (registered)
- stallreq_o  out  1  combinational stall request to the pipeline controller

## Operation
- States: IDLE, ZERO, ON, END.
- IDLE:
  - start_i & ~annul_i & divisor == 0 -> ZERO.
  - start_i & ~annul_i & divisor != 0 -> ON; latch the operands; cnt = 0.
  - Otherwise stay in IDLE.
- Signed mode:
  - Operands are converted to magnitudes (two's-complement negate when bit 31 is set). The magnitude of 0x80000000 is 0x80000000 as unsigned.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
- ON: restoring shift-subtract, MSB first, one quotient bit per cycle.
  - Each step computes a 33-bit difference of the partial remainder minus the divisor.
  - If non-negative, the partial remainder becomes the difference and the quotient bit is 1. Otherwise the quotient bit is 0.
  - cnt increments after each step. After the step with cnt = 31 -> END, and the sign fix-up is applied on that same transition.
- ZERO: the result is defined as 0 (quotient 0, remainder 0) -> END after one cycle.
- END: ready_o = 1 and result_o is held.
  - When start_i = 0 -> IDLE; ready_o and result_o clear to 0 on that edge.
  - If start_i stays high, remain in END.
- annul_i = 1 in ZERO, ON or END -> IDLE on the next edge; ready_o = 0, result_o = 0, partial state discarded.
- stallreq_o = start_i & ~annul_i & ~ready_o. It is forced to 0 while rst = 1.
- Overflow: the signed case 0x80000000 / 0xFFFFFFFF wraps, giving quotient 0x80000000 and remainder 0. No exception is raised.

## Timing
- Reset values: state IDLE, cnt 0, ready_o 0, result_o 0, stallreq_o 0. Reset is asynchronous, so it takes effect mid-divide immediately.
- Counting the cycle in which start_i is first sampled in IDLE as cycle 1:
  - Normal divide: ready_o is high in cycle 34 (32 iteration cycles, 2..33).
  - Divide by zero: ready_o is high in cycle 3.
- stallreq_o is high from cycle 1 until ready_o rises, then low in the same cycle. This lets ID/EX advance on the following edge.
- Operands are sampled only on the IDLE -> ON/ZERO edge. Changes to opdata1_i/opdata2_i after that edge are ignored.
- A new start_i in the cycle right after END -> IDLE is accepted normally. There is no back-to-back start without that IDLE cycle.

## Configuration
- `DIV_EARLY_EXIT_EN` defined: in IDLE, with a nonzero divisor and |dividend| < |divisor| (magnitudes after sign handling), the FSM goes to ZERO-like handling instead of ON. The result is quotient 0 and remainder = the original signed dividend, with ready_o high in cycle 3.
- Macro undefined: every nonzero-divisor case runs the full 32 iterations (ready_o in cycle 34). The result is identical.

## Test plan
- DIVU 100 / 7, start held -> ready_o high in cycle 34, result_o = 0x00000002_0000000E; stallreq_o high in cycles 1–33, low in cycle 34.
- DIV 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000, no hang.
- DIVU 5 / 0 -> ready_o high in cycle 3, result_o = 0.
- Abort and reset recovery:
  - DIVU 9 / 3, annul_i pulsed in cycle 10 -> IDLE in cycle 11 and ready_o never rises. Restarting gives 0x00000000_00000003 in cycle 34.
  - Asserting rst in cycle 20 -> all outputs 0 immediately.
- DIVU 3 / 10 -> with `DIV_EARLY_EXIT_EN`: ready_o in cycle 3. Without it: cycle 34. Both give result_o = 0x00000003_00000000.
